dsp_sequencer: RTL and testbench
================================

// Module: dsp_sequencer
// PURPOSE
//  Job-level controller for the dsp shift-register datapath. Accepts a command giving a word count,
//  streams that many input words into the datapath (din/we), then reads them back by stepping the
//  param index and presents results on a valid/ready stream in arrival order. It sits between the
//  host stream interface and one dsp instance; it is the only driver of the datapath's din/we/param.
// PARAMETERS
//  BUS_WIDTH  24  data word width; equals the datapath bus_width
//  DEPTH      2   max words per job (datapath shift-register capacity in words)
//  IDX_W      8   width of cmd_len and dsp_param
// PORTS
//  clk        in   1          single clock, all logic rising-edge
//  rst        in   1          synchronous, active-high reset
//  cmd_valid  in   1          job request
//  cmd_ready  out  1          high only in IDLE
//  cmd_len    in   IDX_W      words in job, legal 1..DEPTH
//  in_valid   in   1          input word valid
//  in_ready   out  1          high only in LOAD
//  in_data    in   BUS_WIDTH  input word
//  out_valid  out  1          result word valid
//  out_ready  in   1          downstream accepts result
//  out_data   out  BUS_WIDTH  result word
//  out_last   out  1          marks final word of job, qualified by out_valid
//  busy       out  1          high in any state except IDLE
//  done       out  1          one-cycle pulse after the last output handshake
//  err        out  1          one-cycle pulse on an illegal cmd_len
//  dsp_en     out  1          datapath enable, equals busy
//  dsp_we     out  1          datapath shift strobe
//  dsp_din    out  BUS_WIDTH  datapath input word
//  dsp_param  out  IDX_W      datapath read index
//  dsp_dout   in   BUS_WIDTH  datapath output; registered inside the datapath, valid 1 cycle after dsp_param
// BEHAVIOUR
//  Reset: state IDLE; cnt=0, idx=0; outputs out_valid=0, out_last=0, out_data=0, done=0, err=0,
//   dsp_we=0, dsp_din=0, dsp_param=0, busy=0. rst asserted in any state aborts the job in the same
//   edge; a partially loaded job is discarded and no done is produced.
//  States: IDLE -> LOAD -> READ -> CAP -> OUT -> (READ | IDLE).
//  IDLE: cmd_ready=1. On cmd_valid: if cmd_len==0 or cmd_len>DEPTH, pulse err, consume the command,
//   stay in IDLE. Otherwise latch len=cmd_len, cnt=0, go to LOAD.
//  LOAD: in_ready=1; dsp_we=in_valid, dsp_din=in_data combinationally. Each handshake increments cnt.
//   On the handshake where cnt==len-1, go to READ with idx=len-1.
//  Ordering: the newest word sits at index 0, so readback runs idx=len-1 down to 0 (FIFO order).
//  READ: drive dsp_param=idx (registered); go to CAP.
//  CAP: capture dsp_dout into out_data; out_valid=1; out_last=(idx==0); go to OUT.
//  OUT: hold out_data, out_valid and out_last stable until out_ready. On the handshake:
//   if idx==0, pulse done the next cycle, clear out_valid, and go to IDLE; else idx-=1 and go to READ.
//  Throughput is at most one result per 3 cycles; no output bubbles are required beyond this.
//  No read-modify arithmetic on data; idx/cnt are unsigned IDX_W and never wrap in legal operation.
//  A second command while busy is not accepted (cmd_ready=0); in_valid outside LOAD is ignored.
//  dsp_we is never asserted outside LOAD, so a readback never disturbs datapath contents.
// STRUCTURE
//  Shared package dsp_pkg: state enum encoding (IDLE, LOAD, READ, CAP, OUT) and the default
//   BUS_WIDTH, DEPTH and IDX_W localparams, shared with the datapath wrapper.
//  A single flat module; no sub-module. A one-entry output holding register is inline.
// TESTING
//  1 Basic: cmd_len=2, in=0xAAAAAA,0x555555 -> out 0xAAAAAA then 0x555555 (last=1 on 2nd); done 1 cycle after.
//  2 Backpressure: out_ready=0 for 10 cycles in OUT -> out_data/out_valid/out_last stable; no extra dsp_we.
//  3 Illegal length: cmd_len=0, then cmd_len=3 (DEPTH=2) -> err pulse each time, busy stays 0, no dsp_we.
//  4 Input stall: in_valid toggling 1,0,0,1 with cmd_len=2 -> exactly 2 dsp_we pulses; correct order out.
//  5 Reset mid-job: assert rst after 1 of 2 loads -> next cycle IDLE, all outputs zero, no done; a new
//    job with cmd_len=1, in=0x123456 -> out 0x123456 with out_last=1.
//  6 Back-to-back: two jobs with cmd_len=1 -> cmd_ready=0 while busy, second job accepted the cycle after done.

Source files
------------

// File: rtl/dsp_pkg.sv
//------------------------------------------------------------------------------
// Module : dsp_pkg
// Desc   : Shared state encoding and default sizes for the dsp sequencer and datapath.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dsp_pkg;

  localparam int DSP_BUS_WIDTH = 24;
  localparam int DSP_DEPTH     = 2;
  localparam int DSP_IDX_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_READ = 3'd2,
    ST_CAP  = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dsp_sequencer.sv
//------------------------------------------------------------------------------
// Module : dsp_sequencer
// Desc   : Job controller: loads cmd_len words into the dsp datapath, then reads
//          them back in arrival order onto a valid/ready result stream.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int BUS_WIDTH = DSP_BUS_WIDTH,
  parameter int DEPTH     = DSP_DEPTH,
  parameter int IDX_W     = DSP_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [IDX_W-1:0]     cmd_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 dsp_en,
  output logic                 dsp_we,
  output logic [BUS_WIDTH-1:0] dsp_din,
  output logic [IDX_W-1:0]     dsp_param,
  input  logic [BUS_WIDTH-1:0] dsp_dout
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BUS_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    dsp_we      = 1'b0;
    dsp_din     = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0 || cmd_len > IDX_W'(DEPTH)) begin
            err_d = 1'b1;
          end else begin
            len_d   = cmd_len;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        dsp_we   = in_valid;
        dsp_din  = in_data;
        if (in_valid) begin
          cnt_d = cnt_q + IDX_W'(1);
          // Newest word lands at index 0, so readback starts at the oldest.
          if (cnt_q == len_q - IDX_W'(1)) begin
            idx_d   = len_q - IDX_W'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        out_data_d  = dsp_dout;
        out_valid_d = 1'b1;
        out_last_d  = (idx_q == '0);
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_READ;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The read index is the registered idx, so dsp_dout is valid in CAP.
  assign dsp_param = idx_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE);
  assign dsp_en    = busy;

endmodule

`default_nettype wire

// File: tb/tb_dsp_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_dsp_sequencer
// Desc   : Directed self-checking bench for dsp_sequencer with a shift-register datapath model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dsp_sequencer;

  localparam int BW    = 24;
  localparam int DEPTH = 2;
  localparam int IW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;
  logic          dsp_en;
  logic          dsp_we;
  logic [BW-1:0] dsp_din;
  logic [IW-1:0] dsp_param;
  logic [BW-1:0] dsp_dout = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;

  logic [BW-1:0] sr [DEPTH];

  dsp_sequencer #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err),
    .dsp_en(dsp_en), .dsp_we(dsp_we), .dsp_din(dsp_din), .dsp_param(dsp_param), .dsp_dout(dsp_dout)
  );

  always #5 clk = ~clk;

  // Datapath model: newest word at index 0, registered read port.
  always @(posedge clk) begin
    if (dsp_we) begin
      for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= dsp_din;
    end
    dsp_dout <= sr[dsp_param];
    if (dsp_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [IW-1:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push(input logic [BW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: out_valid=%0b required 1", name, out_valid);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_last, done, err, dsp_we, busy, dsp_en} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000", {out_valid, out_last, done, err, dsp_we, busy, dsp_en});
    end
    n_checks++;
    if (out_data !== '0 || dsp_din !== '0 || dsp_param !== '0) begin
      n_fail++;
      $display("FAIL reset_data: out_data=%h dsp_din=%h dsp_param=%h required 0", out_data, dsp_din, dsp_param);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: cmd_ready=%b in_ready=%b required 1/0", cmd_ready, in_ready);
    end
  endtask

  task automatic test_basic();
    int d0;
    send_cmd(8'd2);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_load: busy=%b in_ready=%b cmd_ready=%b required 1/1/0", busy, in_ready, cmd_ready);
    end
    push(24'hAAAAAA);
    push(24'h555555);
    wait_out("basic_w0");
    n_checks++;
    if (out_data !== 24'hAAAAAA || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_w0: data=%h last=%b required aaaaaa/0", out_data, out_last);
    end
    handshake();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_clear: out_valid=%b required 0", out_valid);
    end
    wait_out("basic_w1");
    n_checks++;
    if (out_data !== 24'h555555 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_w1: data=%h last=%b required 555555/1", out_data, out_last);
    end
    d0 = done_cnt;
    handshake();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b valid=%b last=%b required 1/0/0/0", done, busy, out_valid, out_last);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b pulses=%0d required 0/%0d", done, done_cnt - d0, 1);
    end
  endtask

  task automatic test_backpressure();
    int w0;
    int bad = 0;
    send_cmd(8'd2);
    push(24'h000001);
    push(24'h000002);
    wait_out("bp_w0");
    w0 = we_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 24'h000001 || out_last !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stable: %0d unstable cycles data=%h valid=%b required 0", bad, out_data, out_valid);
    end
    n_checks++;
    if (we_cnt != w0) begin
      n_fail++;
      $display("FAIL bp_we: %0d extra dsp_we required 0", we_cnt - w0);
    end
    handshake();
    wait_out("bp_w1");
    n_checks++;
    if (out_data !== 24'h000002 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_w1: data=%h last=%b required 000002/1", out_data, out_last);
    end
    handshake();
    tick();
  endtask

  task automatic test_illegal_len();
    int w0 = we_cnt;
    logic [IW-1:0] lens [2];
    lens[0] = 8'd0;
    lens[1] = 8'd3;
    for (int i = 0; i < 2; i++) begin
      send_cmd(lens[i]);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_err len=%0d: err=%b busy=%b cmd_ready=%b required 1/0/1", lens[i], err, busy, cmd_ready);
      end
      tick();
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_pulse len=%0d: err=%b busy=%b required 0/0", lens[i], err, busy);
      end
    end
    n_checks++;
    if (we_cnt != w0) begin
      n_fail++;
      $display("FAIL illegal_we: %0d dsp_we pulses required 0", we_cnt - w0);
    end
  endtask

  task automatic test_input_stall();
    int w0;
    logic [3:0]    pat;
    logic [BW-1:0] dat [4];
    pat    = 4'b1001;
    dat[0] = 24'h111111;
    dat[1] = 24'h999999;
    dat[2] = 24'h888888;
    dat[3] = 24'h222222;
    send_cmd(8'd2);
    w0 = we_cnt;
    for (int i = 0; i < 4; i++) begin
      in_valid = pat[3-i];
      in_data  = dat[i];
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (we_cnt != w0 + 2) begin
      n_fail++;
      $display("FAIL stall_we: %0d dsp_we pulses required 2", we_cnt - w0);
    end
    wait_out("stall_w0");
    n_checks++;
    if (out_data !== 24'h111111) begin
      n_fail++;
      $display("FAIL stall_w0: data=%h required 111111", out_data);
    end
    handshake();
    wait_out("stall_w1");
    n_checks++;
    if (out_data !== 24'h222222 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_w1: data=%h last=%b required 222222/1", out_data, out_last);
    end
    handshake();
    tick();
  endtask

  task automatic test_reset_mid_job();
    int d0;
    send_cmd(8'd2);
    push(24'hDEAD00);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || dsp_param !== '0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_state: busy=%b valid=%b done=%b param=%h cmd_ready=%b required 0/0/0/00/1",
               busy, out_valid, done, dsp_param, cmd_ready);
    end
    in_valid = 1'b1;
    in_data  = 24'h777777;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    n_checks++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: done pulses=%0d busy=%b required 0/0", done_cnt - d0, busy);
    end
    send_cmd(8'd1);
    push(24'h123456);
    wait_out("rst_new");
    n_checks++;
    if (out_data !== 24'h123456 || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_new_job: data=%h last=%b required 123456/1", out_data, out_last);
    end
    handshake();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_new_done: done=%b required 1", done);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    send_cmd(8'd1);
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy_ready: cmd_ready=%b required 0", cmd_ready);
    end
    push(24'hABCDEF);
    wait_out("b2b_w0");
    n_checks++;
    if (out_data !== 24'hABCDEF || out_last !== 1'b1 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_job1: data=%h last=%b cmd_ready=%b required abcdef/1/0", out_data, out_last, cmd_ready);
    end
    handshake();
    n_checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b cmd_ready=%b required 1/1", done, cmd_ready);
    end
    send_cmd(8'd1);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b in_ready=%b required 1/1", busy, in_ready);
    end
    push(24'h0FEDCB);
    wait_out("b2b_w1");
    n_checks++;
    if (out_data !== 24'h0FEDCB || out_last !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_job2: data=%h last=%b required 0fedcb/1", out_data, out_last);
    end
    handshake();
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b valid=%b required 0/0", busy, out_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) sr[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_illegal_len();
    test_input_stall();
    test_reset_mid_job();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
